// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared processor-side constants for the data-memory responder: default
// memory geometry, FSM state encodings and the request-op type.
// No ports (package).
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

    localparam int unsigned DMEM_ADDR_W = 8;
    localparam int unsigned DMEM_DATA_W = 8;

    // Plain constants rather than an enum so the encodings stay fixed for
    // legacy decode logic that compares against raw values.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

    // A simultaneous read+write request is resolved as a write.
    function automatic mem_op_e decode_op(input logic rd, input logic wr);
        return wr ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// -----------------------------------------------------------------------------
// mem_array_sync
// Single-port synchronous RAM, 2**ADDR_W x DATA_W, with write enable and a
// registered read port that only updates on a read enable. No reset on the
// storage or the read register so it maps onto block RAM.
// Ports:
//   clk_i    clock, rising edge
//   we_i     write enable (mem[addr_i] <= wdata_i)
//   re_i     read enable  (rdata_o <= mem[addr_i])
//   addr_i   address
//   wdata_i  write data
//   rdata_o  registered read data, holds between reads
// -----------------------------------------------------------------------------
module mem_array_sync
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = DMEM_DATA_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Slave end of the memory-stage mem_read/mem_write request. Accepts one
// request at a time, optionally waits WAIT_CYCLES, then accesses the array
// and pulses rdata_valid_o or wr_done_o for one cycle.
//
//   state | meaning
//   IDLE  | no access in flight, ready to accept
//   WAIT  | request captured, counting down to the array access (busy)
//   DONE  | access performed last edge, pulse visible, ready to accept
//
// Ports:
//   clock_i        clock, rising edge
//   reset_i        asynchronous, active-high reset
//   mem_read_i     read request
//   mem_write_i    write request
//   addr_i         request address
//   wdata_i        write data
//   rdata_o        read data, holds until the next read completes
//   rdata_valid_o  one-cycle pulse, rdata_o holds the accepted read's result
//   wr_done_o      one-cycle pulse, write committed to the array
//   busy_o         registered; high means no request is accepted this cycle
//   req_err_o      sticky; read and write requested together at acceptance
// -----------------------------------------------------------------------------
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = DMEM_ADDR_W,
    parameter int unsigned DATA_W      = DMEM_DATA_W,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              wr_done_o,
    output logic              busy_o,
    output logic              req_err_o
);

    localparam bit         HAS_WAIT  = (WAIT_CYCLES != 0);
    localparam logic [3:0] WAIT_INIT = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    mem_op_e           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rvalid_q, rvalid_d;
    logic              wr_done_q, wr_done_d;
    logic              err_q, err_d;
    logic              rseen_q, rseen_d;

    logic              accept;
    mem_op_e           req_op;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign accept = ~busy_q & (mem_read_i | mem_write_i);
    assign req_op = decode_op(mem_read_i, mem_write_i);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rseen_d   = rseen_q;
        rvalid_d  = 1'b0;
        wr_done_d = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = addr_i;
        ram_wdata = wdata_i;

        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    // Access with the captured request; inputs are ignored.
                    ram_addr  = addr_q;
                    ram_wdata = wdata_q;
                    ram_we    = (op_q == OP_WRITE);
                    ram_re    = (op_q == OP_READ);
                    wr_done_d = ram_we;
                    rvalid_d  = ram_re;
                    rseen_d   = rseen_q | ram_re;
                    busy_d    = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                // IDLE and DONE accept identically.
                if (accept) begin
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    op_d    = req_op;
                    if (mem_read_i & mem_write_i) begin
                        err_d = 1'b1;
                    end
                    if (HAS_WAIT) begin
                        cnt_d   = WAIT_INIT;
                        busy_d  = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        // Zero wait: access straight from the request inputs.
                        ram_we    = (req_op == OP_WRITE);
                        ram_re    = (req_op == OP_READ);
                        wr_done_d = ram_we;
                        rvalid_d  = ram_re;
                        rseen_d   = rseen_q | ram_re;
                        state_d   = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            op_q      <= OP_READ;
            addr_q    <= '0;
            wdata_q   <= '0;
            rvalid_q  <= 1'b0;
            wr_done_q <= 1'b0;
            err_q     <= 1'b0;
            rseen_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rvalid_q  <= rvalid_d;
            wr_done_q <= wr_done_d;
            err_q     <= err_d;
            rseen_q   <= rseen_d;
        end
    end

    mem_array_sync #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk_i   (clock_i),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // The RAM read register has no reset (block RAM), so rdata is forced to
    // zero until a read has completed since the last reset.
    assign rdata_o       = rseen_q ? ram_rdata : '0;
    assign rdata_valid_o = rvalid_q;
    assign wr_done_o     = wr_done_q;
    assign busy_o        = busy_q;
    assign req_err_o     = err_q;

endmodule
